agc_gain_scheduler: RTL and testbench
=====================================

Name: agc_gain_scheduler

Overview:
Frame-based gain-update controller for the AGC datapath. It tracks the per-frame peak of the rectified input and sequences one shared multi-cycle divider per frame to compute TARGET/peak. It then clamps and slew-limits the result and commits the gain word that the AGC multiplier consumes. It sits between the input rectifier, the iterative divider and the gain multiplier, and replaces free-running per-sample division.

Parameters:
FRAME_LEN, 1024, samples per frame (counts sample_valid pulses; must be at least 2)
TARGET, 16'hF0A4, divider dividend (target level)
GAIN_MAX, 16'hA000, upper gain clamp, unsigned Q5.11
GAIN_INIT, 16'h0800, gain after reset (1.0 in Q5.11)
RELEASE_STEP, 16'h0400, maximum gain increase per frame
DIV_TIMEOUT, 64, cycles allowed between div_start and div_done

Ports:
clk  in  1  system clock, all logic on its rising edge
reset_x  in  1  asynchronous active-low reset
enable  in  1  block enable; low causes a synchronous clear of the frame state
sample_valid  in  1  abs_sample qualifier, one sample per cycle at most
abs_sample  in  8  unsigned rectified sample, 0..128
div_start  out  1  one-cycle divide request
div_dividend  out  16  equals TARGET
div_divisor  out  16  registered; stable from div_start until div_done
div_done  in  1  one-cycle pulse; div_quotient is valid in the same cycle
div_quotient  in  16  unsigned quotient
gain_out  out  16  committed gain, unsigned Q5.11
gain_update  out  1  one-cycle pulse in the cycle gain_out changes value
overrun  out  1  sticky; a frame ended while the FSM was not IDLE
div_err  out  1  sticky; divider timeout occurred

Behaviour:
- Reset values: gain_out=GAIN_INIT; div_start=0, gain_update=0, overrun=0, div_err=0, div_divisor=0; sample counter=0; peak=0; FSM=IDLE.
- Sticky flags clear only on reset.
- Sample counter: increments on each sample_valid. At count FRAME_LEN-1 with sample_valid, the cycle is a frame end: the counter wraps to 0.
- Peak: on each sample_valid, peak = max(peak, min(abs_sample,127)).
- At frame end, peak_latched = max(peak, current sample), and peak restarts from 0. The frame-end sample therefore belongs to the ending frame.
- FSM states:
  - IDLE: on frame end, go to REQ if peak_latched != 0. If peak_latched == 0, go to APPLY with target = GAIN_MAX and no divide.
  - REQ: drive div_start=1 for exactly one cycle; div_divisor = {peak_latched[6:0], 9'b0}; go to WAIT.
  - WAIT: a timer counts cycles from entry. On div_done, capture the quotient and go to APPLY. If the timer reaches DIV_TIMEOUT without div_done: set div_err, leave gain_out unchanged, go to IDLE.
  - APPLY: form target from the captured quotient as follows.
    - If q[15:5] != 0, then t = 16'hFFFF.
    - Otherwise t = {q[4:0], 11'b0}.
    - Then t = min(t, GAIN_MAX).
    - If t < gain_out (attack): gain_out = t.
    - Otherwise (release): gain_out = min(t, gain_out + RELEASE_STEP), with saturating add.
    - gain_update pulses the same cycle gain_out changes; there is no pulse if the value is unchanged.
    - Next state is IDLE.
- Latency: frame end to gain_out update is 3 + divider latency cycles. The divide-skipped path takes 2 cycles.
- Frame end while the FSM is not IDLE: set overrun and discard that frame's peak_latched. The current operation completes normally.
- div_done outside WAIT is ignored.
- A frame end in the same cycle as an APPLY→IDLE transition counts as an overrun. IDLE is only sampled when the FSM is already IDLE in that cycle.
- enable=0:
  - Counter and peak clear synchronously, and the FSM returns to IDLE.
  - gain_out and the sticky flags are held.
  - An in-flight divide result is dropped.
  - Restarting enable begins a fresh frame at count 0.
- Reset mid-divide: everything returns to reset values. Any later div_done is ignored because the FSM is IDLE.

Decomposition:
- Shared package agc_pkg holds:
  - gain_t (16-bit Q5.11), sample_t (8-bit);
  - localparams GAIN_UNITY=16'h0800 and GAIN_FRAC_BITS=11;
  - the FSM state enum {IDLE, REQ, WAIT, APPLY}.
- One natural sub-module, agc_gain_slew, is combinational: quotient → clamp → attack/release next-gain. This lets it be unit-tested apart from the FSM.
- Counter, peak tracking and FSM stay in the top level.

Test Plan:
- FRAME_LEN=8, constant sample 64, divider model returns TARGET/divisor after 10 cycles → divisor 16'h8000, quotient 1. gain_out stays 16'h0800 with no gain_update, and div_start pulses once per frame.
- From gain_out=16'h0800, frame peak 16 → divisor 16'h2000, quotient 7, t=16'h3800. gain_out steps 16'h0C00, then 16'h1000 on following frames (release limit), with gain_update each time.
- Peak 1 → divisor 16'h0200, quotient 120 → saturate then clamp. If gain_out was 16'hA000, the target 16'hA000 is unchanged; from 16'h0800 the next value is 16'h0C00. Then peak 127 gives quotient 0 → t=0, and gain_out drops to 0 in one frame (attack).
- All-zero frame → no div_start; gain_out ramps toward 16'hA000 by 16'h0400 per frame.
- Divider never asserts div_done → div_err sets DIV_TIMEOUT cycles after div_start and gain_out is unchanged. Next, divider latency > FRAME_LEN → overrun sets and the skipped frame's peak is discarded.
- Assert reset_x low during WAIT → outputs return to reset values immediately. A late div_done is ignored. enable low for 3 cycles mid-frame → the counter restarts and the first frame end occurs after 8 more samples.

Source files
------------

// File: rtl/agc_pkg.sv
// Shared types and constants for the AGC gain scheduler: gain/sample words,
// Q5.11 unity, and the divide-sequencing FSM states.
package agc_pkg;

  typedef logic [15:0] gain_t;
  typedef logic [7:0]  sample_t;

  localparam gain_t GAIN_UNITY     = 16'h0800;
  localparam int    GAIN_FRAC_BITS = 11;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    APPLY
  } agc_state_e;

endpackage

// File: rtl/agc_gain_slew.sv
// Combinational quotient -> clamped target -> attack/release next gain.
// Attack is immediate; release is limited to RELEASE_STEP per frame.
module agc_gain_slew
  import agc_pkg::*;
#(
  parameter gain_t GAIN_MAX     = 16'hA000,
  parameter gain_t RELEASE_STEP = 16'h0400
) (
  input  gain_t quotient_i,
  input  gain_t gain_cur_i,
  output gain_t gain_next_o
);

  gain_t       target;
  logic [16:0] step_sum;
  gain_t       step_sat;

  // NOTE: combinational blocks use blocking '=' so later lines see the
  // updated value of 'target' within the same evaluation.
  always_comb begin
    target = (|quotient_i[15:5]) ? 16'hFFFF
                                 : {quotient_i[4:0], {GAIN_FRAC_BITS{1'b0}}};
    if (target > GAIN_MAX) target = GAIN_MAX;

    step_sum = {1'b0, gain_cur_i} + {1'b0, RELEASE_STEP};
    step_sat = step_sum[16] ? 16'hFFFF : step_sum[15:0];

    if (target < gain_cur_i) gain_next_o = target;
    else                     gain_next_o = (target < step_sat) ? target : step_sat;
  end

endmodule

// File: rtl/agc_gain_scheduler.sv
// Frame-based AGC gain controller: tracks per-frame peak, runs one shared
// divide per frame (TARGET/peak), then commits a clamped, slew-limited gain.
module agc_gain_scheduler
  import agc_pkg::*;
#(
  parameter int    FRAME_LEN    = 1024,
  parameter gain_t TARGET       = 16'hF0A4,
  parameter gain_t GAIN_MAX     = 16'hA000,
  parameter gain_t GAIN_INIT    = GAIN_UNITY,
  parameter gain_t RELEASE_STEP = 16'h0400,
  parameter int    DIV_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [7:0]  abs_sample,
  output logic        div_start,
  output logic [15:0] div_dividend,
  output logic [15:0] div_divisor,
  input  logic        div_done,
  input  logic [15:0] div_quotient,
  output logic [15:0] gain_out,
  output logic        gain_update,
  output logic        overrun,
  output logic        div_err
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int TMR_W = $clog2(DIV_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DIV_TIMEOUT - 1);

  agc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [6:0]       peak_q, peak_d;
  gain_t            quot_q, quot_d;
  gain_t            divisor_q, divisor_d;
  gain_t            gain_q, gain_d;
  logic             upd_q, upd_d;
  logic             overrun_q, overrun_d;
  logic             err_q, err_d;

  logic [6:0] sample_clip;
  logic [6:0] peak_frame;
  logic       frame_end;
  gain_t      gain_next;

  assign sample_clip = (abs_sample > 8'd127) ? 7'd127 : abs_sample[6:0];
  assign peak_frame  = (sample_clip > peak_q) ? sample_clip : peak_q;
  assign frame_end   = enable & sample_valid & (cnt_q == CNT_LAST);

  agc_gain_slew #(
    .GAIN_MAX     (GAIN_MAX),
    .RELEASE_STEP (RELEASE_STEP)
  ) u_slew (
    .quotient_i  (quot_q),
    .gain_cur_i  (gain_q),
    .gain_next_o (gain_next)
  );

  // NOTE: every variable gets its hold value first, so no path through the
  // case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    peak_d    = peak_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    gain_d    = gain_q;
    upd_d     = 1'b0;
    overrun_d = overrun_q;
    err_d     = err_q;

    if (!enable) begin
      cnt_d   = '0;
      peak_d  = '0;
      timer_d = '0;
      state_d = IDLE;
    end else begin
      if (sample_valid) begin
        cnt_d  = frame_end ? '0 : cnt_q + 1'b1;
        peak_d = frame_end ? '0 : peak_frame;
      end
      // A frame ending while busy is dropped; the running operation finishes.
      if (frame_end && state_q != IDLE) overrun_d = 1'b1;

      case (state_q)
        IDLE: begin
          if (frame_end) begin
            if (|peak_frame) begin
              divisor_d = {peak_frame, 9'b0};
              state_d   = REQ;
            end else begin
              quot_d  = 16'hFFFF;  // saturates to GAIN_MAX in the slew stage
              state_d = APPLY;
            end
          end
        end
        REQ: begin
          timer_d = '0;
          state_d = WAIT;
        end
        WAIT: begin
          if (div_done) begin
            quot_d  = div_quotient;
            state_d = APPLY;
          end else if (timer_q == TMR_LAST) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        APPLY: begin
          gain_d  = gain_next;
          upd_d   = (gain_next != gain_q);
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update
  // together from pre-edge values.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timer_q   <= '0;
      peak_q    <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      gain_q    <= GAIN_INIT;
      upd_q     <= 1'b0;
      overrun_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      peak_q    <= peak_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      gain_q    <= gain_d;
      upd_q     <= upd_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
    end
  end

  assign div_start    = (state_q == REQ);
  assign div_dividend = TARGET;
  assign div_divisor  = divisor_q;
  assign gain_out     = gain_q;
  assign gain_update  = upd_q;
  assign overrun      = overrun_q;
  assign div_err      = err_q;

endmodule

// File: tb/tb_agc_gain_scheduler.sv
// Directed bench for agc_gain_scheduler with FRAME_LEN=8 and a behavioural
// iterative divider with programmable latency (or no response at all).
module tb_agc_gain_scheduler;

  localparam int          FL  = 8;
  localparam logic [15:0] TGT = 16'hF0A4;
  localparam int          TMO = 64;

  logic        clk = 1'b0;
  logic        reset_x = 1'b0;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic [7:0]  abs_sample = 8'd0;
  logic        div_done = 1'b0;
  logic [15:0] div_quotient = 16'd0;
  logic        div_start;
  logic [15:0] div_dividend;
  logic [15:0] div_divisor;
  logic [15:0] gain_out;
  logic        gain_update;
  logic        overrun;
  logic        div_err;

  agc_gain_scheduler #(.FRAME_LEN(FL)) dut (
    .clk          (clk),
    .reset_x      (reset_x),
    .enable       (enable),
    .sample_valid (sample_valid),
    .abs_sample   (abs_sample),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_done     (div_done),
    .div_quotient (div_quotient),
    .gain_out     (gain_out),
    .gain_update  (gain_update),
    .overrun      (overrun),
    .div_err      (div_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_start = 0;
  int n_upd   = 0;

  int          div_lat  = 10;
  bit          div_hang = 1'b0;
  bit          div_busy = 1'b0;
  int          div_cnt  = 0;
  logic [15:0] div_dv   = 16'd0;
  logic [15:0] last_divisor = 16'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (div_start === 1'b1)   n_start++;
    if (gain_update === 1'b1) n_upd++;
  end

  // Behavioural divider: quotient returned div_lat cycles after the request.
  always @(negedge clk) begin
    div_done = 1'b0;
    if (div_busy) begin
      div_cnt--;
      if (div_cnt == 0) begin
        div_busy = 1'b0;
        if (!div_hang) begin
          div_done     = 1'b1;
          div_quotient = (div_dv == 16'd0) ? 16'hFFFF : TGT / div_dv;
        end
      end
    end else if (div_start === 1'b1) begin
      div_busy     = 1'b1;
      div_cnt      = div_lat;
      div_dv       = div_divisor;
      last_divisor = div_divisor;
    end
  end

  task automatic samples(input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      abs_sample   = v;
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int u0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_gain",     gain_out,     16'h0800);
    check("rst_start",    div_start,    1'b0);
    check("rst_update",   gain_update,  1'b0);
    check("rst_overrun",  overrun,      1'b0);
    check("rst_div_err",  div_err,      1'b0);
    check("rst_divisor",  div_divisor,  16'h0000);
    check("dividend",     div_dividend, TGT);
    reset_x = 1'b1;
    enable  = 1'b1;

    // Constant 64: divisor 8000, quotient 1, gain stays at unity.
    samples(FL, 8'd64); idle(20);
    check("s64_divisor", last_divisor, 16'h8000);
    check("s64_starts",  n_start, 1);
    check("s64_updates", n_upd, 0);
    check("s64_gain",    gain_out, 16'h0800);
    samples(FL, 8'd64); idle(20);
    check("s64_starts2", n_start, 2);
    check("s64_gain2",   gain_out, 16'h0800);

    // Peak 16: quotient 7 -> target 3800, release-limited steps.
    samples(FL, 8'd16); idle(20);
    check("p16_divisor", last_divisor, 16'h2000);
    check("p16_gain1",   gain_out, 16'h0C00);
    check("p16_upd1",    n_upd, 1);
    samples(FL, 8'd16); idle(20);
    check("p16_gain2",   gain_out, 16'h1000);
    check("p16_upd2",    n_upd, 2);

    // Peak 1: quotient 120 saturates and clamps, still release-limited.
    samples(FL, 8'd1); idle(20);
    check("p1_divisor",  last_divisor, 16'h0200);
    check("p1_gain",     gain_out, 16'h1400);
    // Sample 128 clips to 127: quotient 0, immediate attack to 0.
    samples(FL, 8'd128); idle(20);
    check("p127_divisor", last_divisor, 16'hFE00);
    check("p127_gain",    gain_out, 16'h0000);
    check("p127_upd",     n_upd, 4);

    // All-zero frames: no divide, ramp by 0400 to the A000 clamp.
    s0 = n_start;
    u0 = n_upd;
    samples(FL, 8'd0);
    @(negedge clk); sample_valid = 1'b0;
    @(negedge clk); #1;
    check("skip_latency", gain_update, 1'b1);
    check("skip_gain1",   gain_out, 16'h0400);
    idle(4);
    for (int i = 0; i < 39; i++) begin
      samples(FL, 8'd0); idle(4);
    end
    check("ramp_gain",    gain_out, 16'hA000);
    check("ramp_nostart", n_start, s0);
    check("ramp_updates", n_upd - u0, 40);
    u0 = n_upd;
    samples(FL, 8'd0); idle(4);
    check("clamp_noupd",  n_upd, u0);
    samples(FL, 8'd1); idle(20);
    check("clamp_gain",   gain_out, 16'hA000);
    check("clamp_noupd2", n_upd, u0);
    check("clamp_start",  n_start, s0 + 1);

    // Divider never answers: timeout after DIV_TIMEOUT cycles.
    div_hang = 1'b1;
    samples(FL, 8'd16);
    @(negedge clk); sample_valid = 1'b0; #1;
    check("tmo_start", div_start, 1'b1);
    repeat (TMO - 1) @(negedge clk);
    #1;
    check("tmo_early", div_err, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("tmo_err",   div_err, 1'b1);
    check("tmo_gain",  gain_out, 16'hA000);
    idle(10);
    div_hang = 1'b0;

    // Divide slower than a frame: second frame discarded, overrun sticky.
    div_lat = 12;
    s0 = n_start;
    samples(FL, 8'd16);
    samples(FL, 8'd128);
    idle(30);
    check("ovr_flag",   overrun, 1'b1);
    check("ovr_gain",   gain_out, 16'h3800);
    check("ovr_starts", n_start, s0 + 1);
    check("err_sticky", div_err, 1'b1);

    // Reset while waiting on the divider; the late result is ignored.
    div_lat = 10;
    samples(FL, 8'd64);
    @(negedge clk); sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_x = 1'b0;
    #1;
    check("mid_rst_gain",    gain_out, 16'h0800);
    check("mid_rst_err",     div_err, 1'b0);
    check("mid_rst_overrun", overrun, 1'b0);
    check("mid_rst_divisor", div_divisor, 16'h0000);
    check("mid_rst_start",   div_start, 1'b0);
    u0 = n_upd;
    @(negedge clk); reset_x = 1'b1;
    idle(20);
    check("late_done_upd",  n_upd, u0);
    check("late_done_gain", gain_out, 16'h0800);

    // Enable low mid-frame: counter and peak restart.
    samples(5, 8'd128);
    @(negedge clk); sample_valid = 1'b0; enable = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk); enable = 1'b1;
    s0 = n_start;
    samples(FL - 1, 8'd16); idle(5);
    check("en_no_early_end", n_start, s0);
    samples(1, 8'd16); idle(20);
    check("en_frame_end", n_start, s0 + 1);
    check("en_divisor",   last_divisor, 16'h2000);
    check("en_gain",      gain_out, 16'h0C00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
